// File: rtl/segs_pkg.sv
// ---------------------------------------------------------------------------
// segs_pkg
// Shared definitions for users of segs_ctrl. Provides the default
// requester count and hold time, the display word geometry, the arbiter
// FSM encodings and a helper that sizes index fields.
// ---------------------------------------------------------------------------
package segs_pkg;

    // Default arbiter configuration
    localparam int SEGS_NUM_REQ_DEF     = 4;
    localparam int SEGS_HOLD_CYCLES_DEF = 16;

    // Display word geometry: six 4-bit digits, one enable per digit
    localparam int SEGS_DIGITS  = 6;
    localparam int SEGS_DIGIT_W = 4;
    localparam int SEGS_DATA_W  = SEGS_DIGITS * SEGS_DIGIT_W;

    // The hold counter covers the full legal HOLD_CYCLES range (1..65535)
    localparam int HOLD_CNT_W = 16;

    // Arbiter FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Width of an index into n requesters; never zero, so that a
    // single-requester build still gets a legal one-bit vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : segs_pkg

// File: rtl/segs_display_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. It finds the first set request bit,
// scanning upward from i_last_idx+1 and wrapping modulo NUM_REQ. When
// i_exclude_last is set, the i_last_idx position is skipped. This skip is
// used while an owner holds the display, so the search can only pick a
// different requester.
//
// Ports
//   i_req          : request vector, one bit per requester
//   i_last_idx     : most recently granted index (scan starts just above it)
//   i_exclude_last : skip i_last_idx itself
//   o_found        : at least one eligible request exists
//   o_idx          : index of the chosen requester (0 when none found)
// ---------------------------------------------------------------------------
module rr_pick
    import segs_pkg::*;
#(
    parameter int NUM_REQ = SEGS_NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_idx,
    input  logic               i_exclude_last,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_upper;  // eligible requests above the last index
    logic [NUM_REQ-1:0] w_wrap;   // eligible requests on the wrapped pass

    always_comb begin
        // NOTE: every combinational output gets a default before any branch
        // or loop. If a path left a signal unassigned, a latch would be
        // inferred.
        w_upper = '0;
        w_wrap  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper[i] = i_req[i] && (i > int'(i_last_idx));
            w_wrap[i]  = i_req[i] && !(i_exclude_last && (i == int'(i_last_idx)));
        end
    end

    // The lowest set bit above the last index wins. Otherwise the search
    // wraps and the lowest eligible bit overall wins. Scanning downward
    // leaves the lowest match in o_idx without needing a found flag.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        if (|w_upper) begin
            o_found = 1'b1;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_upper[i]) o_idx = IDX_W'(i);
            end
        end else if (|w_wrap) begin
            o_found = 1'b1;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_wrap[i]) o_idx = IDX_W'(i);
            end
        end
    end

endmodule : rr_pick

// File: rtl/segs_display_arbiter.sv
// ---------------------------------------------------------------------------
// segs_display_arbiter
// Shares one six-digit display among NUM_REQ requesters.
//
// A two-state FSM (IDLE / OWN) grants the display to one requester at a
// time, using round-robin order. An owner keeps the display for at least
// HOLD_CYCLES cycles while it keeps requesting. Once that time has passed,
// another requester may take over. An owner that drops its request gives
// up the display at the next edge, and a waiting requester takes over with
// no empty cycle in between.
//
// Data and enables follow the owner's slice with one cycle of latency. They
// freeze while nobody owns the display.
//
// Ports
//   i_clk             : clock, all state changes on its rising edge
//   i_rst             : asynchronous active-high reset
//   i_req             : per-requester level-sensitive request
//   i_req_data        : six 4-bit digits per requester, slice i at [24i +: 24]
//   i_req_enables     : six digit enables per requester, slice i at [6i +: 6]
//   o_grant           : one-hot (or zero) current owner
//   o_data            : registered digit word for segs_ctrl
//   o_display_enables : registered digit enables for segs_ctrl
//   o_busy            : high whenever o_grant is non-zero
// ---------------------------------------------------------------------------
module segs_display_arbiter
    import segs_pkg::*;
#(
    parameter int NUM_REQ     = SEGS_NUM_REQ_DEF,
    parameter int HOLD_CYCLES = SEGS_HOLD_CYCLES_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [SEGS_DATA_W*NUM_REQ-1:0] i_req_data,
    input  logic [SEGS_DIGITS*NUM_REQ-1:0] i_req_enables,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [SEGS_DATA_W-1:0]         o_data,
    output logic [SEGS_DIGITS-1:0]         o_display_enables,
    output logic                           o_busy
);

    localparam int                    IDX_W    = idx_width(NUM_REQ);
    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [IDX_W-1:0]       r_last_idx;   // equals the owner index while in OWN
    logic [HOLD_CNT_W-1:0]  r_hold_cnt;
    logic [SEGS_DATA_W-1:0] r_data;
    logic [SEGS_DIGITS-1:0] r_enables;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                   w_in_own;
    logic                   w_owner_req;
    logic                   w_expired;
    logic                   w_pick_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [NUM_REQ-1:0]     w_pick_onehot;
    logic                   w_take_pick;
    logic                   w_go_idle;
    logic [SEGS_DATA_W-1:0] w_owner_data;
    logic [SEGS_DIGITS-1:0] w_owner_enables;

    logic [0:0]             w_state_nxt;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic [IDX_W-1:0]       w_last_idx_nxt;
    logic [HOLD_CNT_W-1:0]  w_hold_cnt_nxt;

    assign w_in_own    = (r_state == ST_OWN);
    assign w_owner_req = |(i_req & r_grant);
    assign w_expired   = (r_hold_cnt == HOLD_MAX);

    // While in OWN, the search skips the owner. Any hit therefore means
    // that another requester is waiting.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req          (i_req),
        .i_last_idx     (r_last_idx),
        .i_exclude_last (w_in_own),
        .o_found        (w_pick_found),
        .o_idx          (w_pick_idx)
    );

    always_comb begin
        w_pick_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pick_onehot[i] = (w_pick_idx == IDX_W'(i));
        end
    end

    // The owner's slice is selected by the one-hot grant. The result is
    // zero when idle, but it is only loaded while in OWN.
    always_comb begin
        w_owner_data    = '0;
        w_owner_enables = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_data    = i_req_data[i*SEGS_DATA_W +: SEGS_DATA_W];
                w_owner_enables = i_req_enables[i*SEGS_DIGITS +: SEGS_DIGITS];
            end
        end
    end

    // A new grant is made from IDLE on any request. In OWN, it is made when
    // the owner has released, or when its hold time has expired and
    // someone else is waiting. Release is checked before expiry, so a
    // dropped request is never held for the rest of the hold time.
    always_comb begin
        if (w_in_own) begin
            w_take_pick = w_pick_found && (!w_owner_req || w_expired);
            w_go_idle   = !w_owner_req && !w_pick_found;
        end else begin
            w_take_pick = w_pick_found;
            w_go_idle   = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_idx_nxt = r_last_idx;
        w_hold_cnt_nxt = r_hold_cnt;
        if (w_take_pick) begin
            w_state_nxt    = ST_OWN;
            w_grant_nxt    = w_pick_onehot;
            w_last_idx_nxt = w_pick_idx;
            w_hold_cnt_nxt = '0;
        end else if (w_go_idle) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
        end else if (w_in_own && !w_expired) begin
            // Saturate at HOLD_CYCLES-1 so that expiry stays asserted.
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_last_idx <= IDX_LAST;   // the scan then starts at requester 0
            r_hold_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // All flops then sample the pre-edge values, whatever order the
            // statements appear in.
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // The display word loads the current owner's slice at the end of every
    // owned cycle. It freezes while idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data    <= '0;
            r_enables <= '0;
        end else if (w_in_own) begin
            r_data    <= w_owner_data;
            r_enables <= w_owner_enables;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every output is a flop, or a direct decode of the state flop
    // ------------------------------------------------------------------
    assign o_grant           = r_grant;
    assign o_data            = r_data;
    assign o_display_enables = r_enables;
    assign o_busy            = w_in_own;

endmodule : segs_display_arbiter

// File: tb/tb_segs_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_segs_display_arbiter
// Self-checking bench for segs_display_arbiter with NUM_REQ=4 and
// HOLD_CYCLES=4. The reference model tracks the owner as an integer
// (-1 = none). It computes the next owner by modular scanning over the
// request vector, and the display word as the owner's slice from the cycle
// before.
// ---------------------------------------------------------------------------
module tb_segs_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [95:0]  req_data;
    logic [23:0]  req_en;
    logic [N-1:0] o_grant;
    logic [23:0]  o_data;
    logic [5:0]   o_display_enables;
    logic         o_busy;

    int n_cmp;
    int n_fail;

    // Reference model state
    int          m_owner;
    int          m_last;
    int          m_hold;
    logic [23:0] m_data;
    logic [5:0]  m_en;

    logic [23:0] held_word;

    segs_display_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (H)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req             (req),
        .i_req_data        (req_data),
        .i_req_enables     (req_en),
        .o_grant           (o_grant),
        .o_data            (o_data),
        .o_display_enables (o_display_enables),
        .o_busy            (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_bit(input int idx);
        return ((req >> idx) & 4'b0001) != 4'b0000;
    endfunction

    // First requester after 'from', in modular order, skipping 'skip'.
    function automatic int rr_next(input int from, input int skip);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (c != skip && req_bit(c)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_data  = '0;
        m_en    = '0;
    endtask

    task automatic model_step();
        int          nxt;
        bit          owner_req;
        logic [95:0] dsh;
        logic [23:0] esh;
        nxt = -1;
        if (m_owner >= 0) begin
            dsh    = req_data >> (m_owner * 24);
            esh    = req_en >> (m_owner * 6);
            m_data = dsh[23:0];
            m_en   = esh[5:0];
        end
        if (m_owner < 0) begin
            nxt = rr_next(m_last, -1);
        end else begin
            owner_req = req_bit(m_owner);
            if (!owner_req || m_hold == H - 1) nxt = rr_next(m_owner, m_owner);
            if (nxt < 0) begin
                if (!owner_req) m_owner = -1;
                else if (m_hold < H - 1) m_hold++;
            end
        end
        if (nxt >= 0) begin
            m_owner = nxt;
            m_last  = nxt;
            m_hold  = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_grant;
        exp_grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check({tag, "_grant"}, 32'(o_grant), 32'(exp_grant));
        check({tag, "_busy"},  32'(o_busy),  32'(m_owner >= 0));
        check({tag, "_data"},  32'(o_data),  32'(m_data));
        check({tag, "_en"},    32'(o_display_enables), 32'(m_en));
    endtask

    // One clock edge: the model advances on the same inputs, and the outputs
    // are compared 1 time unit after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_outputs(tag);
    endtask

    // Reset pulsed between edges. The outputs must clear before any edge.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_data = {$urandom, $urandom, $urandom};
        req_en   = 24'($urandom);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // First grant goes to requester 0; data follows one edge later
        req            = 4'b0101;
        req_data[23:0] = 24'h012345;
        req_en[5:0]    = 6'h3F;
        cycle("first_grant");
        check("first_grant_onehot", 32'(o_grant), 32'h1);
        cycle("first_data");
        check("first_data_lat", 32'(o_data), 32'h012345);
        check("first_en_lat", 32'(o_display_enables), 32'h3F);

        // Owner 0 keeps requesting, requester 2 waits until the hold expires
        for (int k = 0; k < 2; k++) begin
            cycle("hold");
            check("hold_owner0", 32'(o_grant), 32'h1);
        end
        cycle("rotate");
        check("rotate_to2", 32'(o_grant), 32'h4);

        // Owner 2 drops in hold cycle 1 while requester 1 waits: direct handoff
        req = 4'b0110;
        cycle("pre_drop");
        check("pre_drop_owner2", 32'(o_grant), 32'h4);
        req = 4'b0010;
        cycle("handoff");
        check("handoff_to1", 32'(o_grant), 32'h2);
        check("handoff_busy", 32'(o_busy), 32'h1);

        // Sole owner drops: idle next edge, word frozen while inputs churn
        held_word = req_data[47:24];
        req = 4'b0000;
        cycle("release");
        check("release_grant", 32'(o_grant), 32'h0);
        check("release_busy", 32'(o_busy), 32'h0);
        for (int k = 0; k < 12; k++) begin
            req_data = {$urandom, $urandom, $urandom};
            req_en   = 24'($urandom);
            cycle("frozen");
            check("frozen_word", 32'(o_data), 32'(held_word));
        end

        // Reset pulsed while owning, then lowest index wins
        req = 4'b0100;
        cycle("pre_rst_grant");
        cycle("pre_rst_hold");
        reset_pulse("mid_rst");
        check("mid_rst_grant", 32'(o_grant), 32'h0);
        check("mid_rst_data", 32'(o_data), 32'h0);
        req = 4'b1010;
        cycle("post_rst");
        check("post_rst_lowest", 32'(o_grant), 32'h2);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            req_data = {$urandom, $urandom, $urandom};
            req_en   = 24'($urandom);
            if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_segs_display_arbiter

// File: doc/segs_display_arbiter.md
SEGS_DISPLAY_ARBITER -- requirements
Module: segs_display_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the six-digit display.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum Clock cycles an owner keeps the display before it can be preempted (legal range 1..65535).
REQ-003 Clock  in  1  single clock for the block; all state changes on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Req  in  NUM_REQ  per-requester display request, level-sensitive.
REQ-006 ReqData  in  24*NUM_REQ  six 4-bit digits per requester; requester i occupies bits [24i+23:24i].
REQ-007 ReqEnables  in  6*NUM_REQ  per-requester digit enables; requester i occupies bits [6i+5:6i].
REQ-008 Grant  out  NUM_REQ  one-hot or zero; marks the current display owner.
REQ-009 Data  out  24  registered digit word for segs_ctrl.Data.
REQ-010 DisplayEnables  out  6  registered enables for segs_ctrl.DisplayEnables.
REQ-011 Busy  out  1  high whenever Grant is non-zero.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE (no owner) and OWN (one owner); Grant SHALL never have more than one bit set.
REQ-013 IDLE, any Req set: at the next edge, grant the first requesting index found scanning round-robin from LastIdx+1, modulo NUM_REQ; enter OWN; clear HoldCnt to 0.
REQ-014 IDLE, no Req: remain IDLE; Grant=0; Data and DisplayEnables hold their last values.
REQ-015 OWN: HoldCnt SHALL increment each cycle and saturate at HOLD_CYCLES-1; Expired = (HoldCnt == HOLD_CYCLES-1).
REQ-016 OWN, owner Req low, another Req high: hand off directly at the next edge to the round-robin next requester, with no bubble cycle; clear HoldCnt.
REQ-017 OWN, owner Req low, no other Req: go to IDLE at the next edge; Grant=0.
REQ-018 OWN, owner Req high, Expired, another Req high: rotate the grant to the round-robin next requester (owner excluded); clear HoldCnt.
REQ-019 OWN, owner Req high, not Expired: keep the grant regardless of other requests.
REQ-020 OWN, owner Req high, no other Req: keep the grant indefinitely.
REQ-021 Release takes precedence over hold: a dropped owner Req SHALL never be held for the remainder of HOLD_CYCLES.
REQ-022 LastIdx SHALL update to the newly granted index on every grant or handoff.
REQ-023 Data/DisplayEnables load timing: in every cycle with Grant[i]=1, both outputs SHALL load slice i at the edge ending that cycle. Data therefore follows the owner's ReqData with exactly 1 cycle of latency after Grant rises.
REQ-024 Freeze rule: Data/DisplayEnables SHALL change only while Busy=1, or on Reset.
REQ-025 Req bits with index >= NUM_REQ do not exist; all-zero Req in OWN is covered by REQ-017.

Reset
REQ-026 Reset SHALL asynchronously force: state IDLE, Grant=0, Busy=0, Data=24'h000000, DisplayEnables=6'b000000, HoldCnt=0, LastIdx=NUM_REQ-1 (so requester 0 wins first).
REQ-027 Reset asserted mid-ownership SHALL drop Grant immediately, without waiting for a clock.
REQ-028 After Reset deasserts, the first grant follows REQ-013.

Structure
REQ-029 State encodings (IDLE=0, OWN=1) and the NUM_REQ/HOLD_CYCLES defaults SHALL live in the shared segs package/include used by segs_ctrl users.
REQ-030 The round-robin search SHALL be one combinational sub-module, rr_pick. Inputs: Req, LastIdx, exclude-owner flag. Outputs: found flag, index.
REQ-031 All outputs SHALL be registered; no combinational path from Req to Grant.
REQ-032 The block SHALL instantiate nothing else; its Data and DisplayEnables outputs connect directly to segs_ctrl.

Verification
REQ-033 All scenarios use NUM_REQ=4 and HOLD_CYCLES=4.
REQ-034 Reset, then Req=4'b0101, ReqData0=24'h012345, ReqEnables0=6'h3F -> Grant=4'b0001 after 1 edge; Data=24'h012345 and DisplayEnables=6'h3F one edge later.
REQ-035 Owner 0 holds Req; Req2 raised 1 cycle after grant -> Grant stays 4'b0001 until HoldCnt=3, then becomes 4'b0100 at the next edge.
REQ-036 Owner 2 drops Req in cycle 1 of hold while Req1 is high -> Grant=4'b0010 at the next edge, with no Grant=0 cycle.
REQ-037 Sole owner drops Req -> Grant=0 and Busy=0 at the next edge; Data holds its last value for more than 10 cycles.
REQ-038 Reset pulsed mid-OWN between clock edges -> Grant, Data and Busy read 0 before the next edge; the next grant goes to the lowest requesting index.
